ones_comp_checksum: RTL and testbench

Sequential ones'-complement checksum accumulator. It consumes a packet of WIDTH-bit words over a valid/ready stream and folds each accepted word into a running ones'-complement sum, using an end-around-carry add of the accumulator and the incoming word. At packet end it presents the final sum and its bitwise complement (the checksum) to a downstream consumer, holding them until acknowledged. It sits directly downstream of the packet source and wraps the 4-bit ones'-complement adder datapath in a stateful, per-packet accumulation loop.

---
 rtl/ones_comp_checksum.sv | 140 ++++++++++++++
 tb/tb_ones_comp_checksum.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ones_comp_checksum.sv
// Per-packet ones'-complement checksum accumulator: folds valid/ready stream words
// into an end-around-carry sum and holds sum/checksum/word_count until acknowledged.

module ones_comp_add #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);
    // First stage: plain ripple add. Its carry-out is fed back in as the carry-in of
    // an increment stage. That stage cannot overflow: when the carry is set, the low
    // part is at most 2^WIDTH-2.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] inc_carry;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
            assign partial[gi]  = a_i[gi] ^ b_i[gi] ^ carry[gi];
            assign carry[gi+1]  = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
        end
    endgenerate

    assign inc_carry[0] = carry[WIDTH];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_eac
            assign sum_o[gi] = partial[gi] ^ inc_carry[gi];
            if (gi < WIDTH - 1) begin : g_chain
                assign inc_carry[gi+1] = partial[gi] & inc_carry[gi];
            end
        end
    endgenerate

endmodule

module ones_comp_checksum #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             sum_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] checksum,
    output logic [7:0]       word_count,
    input  logic             out_ack,
    output logic             busy
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] checksum_q, checksum_d;
    logic [7:0]       count_q, count_d;
    logic [WIDTH-1:0] acc_add;
    logic             accept;

    ones_comp_add #(.WIDTH(WIDTH)) u_add (
        .a_i   (acc_q),
        .b_i   (in_data),
        .sum_o (acc_add)
    );

    assign accept = (state_q == ST_ACCUM) && in_valid;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sum_d      = sum_q;
        checksum_d = checksum_q;
        count_d    = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    count_d = 8'd0;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_d = acc_add;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                    // Result registers load on the final word so they are valid
                    // on the same cycle the DONE state is entered.
                    if (in_last) begin
                        state_d    = ST_DONE;
                        sum_d      = acc_add;
                        checksum_d = ~acc_add;
                    end
                end
            end
            ST_DONE: begin
                if (out_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            sum_q      <= '0;
            checksum_q <= '0;
            count_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sum_q      <= sum_d;
            checksum_q <= checksum_d;
            count_q    <= count_d;
        end
    end

    assign in_ready   = (state_q == ST_ACCUM);
    assign sum_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign sum        = sum_q;
    assign checksum   = checksum_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_ones_comp_checksum.sv
// Directed bench for ones_comp_checksum with hand-computed sums and checksums.

module tb_ones_comp_checksum;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       sum_valid;
    logic [3:0] sum;
    logic [3:0] checksum;
    logic [7:0] word_count;
    logic       out_ack;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ones_comp_checksum #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .sum_valid  (sum_valid),
        .sum        (sum),
        .checksum   (checksum),
        .word_count (word_count),
        .out_ack    (out_ack),
        .busy       (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pkt();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] w, input logic last);
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic ack();
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'hF;
        in_last  = 1'b1;
        out_ack  = 1'b0;
        step();
        step();
        check_val("rst_in_ready",  in_ready,   0);
        check_val("rst_sum_valid", sum_valid,  0);
        check_val("rst_busy",      busy,       0);
        check_val("rst_sum",       sum,        0);
        check_val("rst_checksum",  checksum,   0);
        check_val("rst_count",     word_count, 0);
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;

        // out_ack in IDLE has no effect
        ack();
        check_val("idle_ack_busy", busy, 0);
        check_val("idle_ack_sv",   sum_valid, 0);

        // No carry: 0011 + 0100 = 0111
        start_pkt();
        check_val("nc_in_ready", in_ready, 1);
        check_val("nc_busy",     busy,     1);
        send(4'b0011, 1'b0);
        check_val("nc_sv_mid", sum_valid, 0);
        send(4'b0100, 1'b1);
        check_val("nc_sum_valid", sum_valid,  1);
        check_val("nc_in_ready0", in_ready,   0);
        check_val("nc_sum",       sum,        4'b0111);
        check_val("nc_checksum",  checksum,   4'b1000);
        check_val("nc_count",     word_count, 2);
        ack();
        check_val("nc_ack_sv",   sum_valid, 0);
        check_val("nc_ack_busy", busy,      0);
        check_val("nc_idle_sum", sum,       4'b0111);

        // End-around carry: 1010+1001 -> 0100, 0100+1111 -> 0100
        start_pkt();
        send(4'b1010, 1'b0);
        send(4'b1001, 1'b0);
        send(4'b1111, 1'b1);
        check_val("eac_sum",      sum,        4'b0100);
        check_val("eac_checksum", checksum,   4'b1011);
        check_val("eac_count",    word_count, 3);
        ack();

        // Negative zero kept as all-ones
        start_pkt();
        send(4'b0101, 1'b0);
        send(4'b1010, 1'b1);
        check_val("nz_sum",      sum,      4'b1111);
        check_val("nz_checksum", checksum, 4'b0000);
        ack();
        start_pkt();
        send(4'b0000, 1'b1);
        check_val("zero_sum",      sum,        4'b0000);
        check_val("zero_checksum", checksum,   4'b1111);
        check_val("zero_count",    word_count, 1);
        ack();

        // Handshake stall with gaps and delayed ack under noisy inputs
        start_pkt();
        send(4'b0001, 1'b0);
        step();
        step();
        check_val("st_gap_ready", in_ready, 1);
        check_val("st_gap_count", word_count, 1);
        send(4'b0010, 1'b1);
        in_valid = 1'b1;
        in_data  = 4'b1111;
        in_last  = 1'b1;
        start    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_val("st_hold_sv",    sum_valid,  1);
            check_val("st_hold_rdy",   in_ready,   0);
            check_val("st_hold_sum",   sum,        4'b0011);
            check_val("st_hold_count", word_count, 2);
            step();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_val("st_pre_ack_sum", sum, 4'b0011);
        ack();
        check_val("st_ack_busy", busy,      0);
        check_val("st_ack_sv",   sum_valid, 0);
        check_val("st_ack_sum",  sum,       4'b0011);

        // Reset mid-packet discards partial sum
        start_pkt();
        send(4'b0111, 1'b0);
        send(4'b0110, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("rm_sv",    sum_valid,  0);
        check_val("rm_busy",  busy,       0);
        check_val("rm_count", word_count, 0);
        start_pkt();
        send(4'b0001, 1'b1);
        check_val("rm_sum",   sum,        4'b0001);
        check_val("rm_count1", word_count, 1);
        ack();

        // Saturating word count: 300 zero words
        start_pkt();
        for (int i = 0; i < 299; i++) begin
            send(4'b0000, 1'b0);
        end
        send(4'b0000, 1'b1);
        check_val("sat_sv",       sum_valid,  1);
        check_val("sat_count",    word_count, 255);
        check_val("sat_sum",      sum,        4'b0000);
        check_val("sat_checksum", checksum,   4'b1111);
        ack();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
